// File: rtl/us_delay_arbiter_pkg.sv
// Shared types and helpers for the microsecond delay arbiter.
package us_delay_pkg;

    localparam int unsigned DELAY_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Returns 0 for a non-integer ratio so the caller's DIV >= 2 check rejects it.
    function automatic int unsigned calc_div(input int unsigned in_freq,
                                             input int unsigned tick_freq);
        if (tick_freq == 0 || (in_freq % tick_freq) != 0) begin
            return 0;
        end
        return in_freq / tick_freq;
    endfunction

endpackage

// File: rtl/us_delay_arbiter_if.sv
// Requester-side bus of the shared microsecond delay timer.
// US_DELAY_MS_UNIT_EN adds the per-requester unit_ms select.
interface us_delay_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DELAY_W = us_delay_pkg::DELAY_W_DEFAULT
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DELAY_W-1:0] delay;
`ifdef US_DELAY_MS_UNIT_EN
    logic [NUM_REQ-1:0]         unit_ms;
`endif
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         done;
    logic                       busy;
    logic                       us_tick;

`ifdef US_DELAY_MS_UNIT_EN
    modport master (output req, delay, unit_ms, input gnt, done, busy, us_tick);
    modport slave  (input req, delay, unit_ms, output gnt, done, busy, us_tick);
`else
    modport master (output req, delay, input gnt, done, busy, us_tick);
    modport slave  (input req, delay, output gnt, done, busy, us_tick);
`endif

endinterface

// File: rtl/us_delay_arbiter_tick_gen.sv
// Prescaler producing a one-cycle tick enable every DIV clocks, with a
// synchronous restart so a new delay starts phase-aligned.
module us_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(DIV - 1));
    assign o_tick = w_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/us_delay_arbiter.sv
// Round-robin arbiter sharing one microsecond timer among NUM_REQ requesters.
// Optional US_DELAY_MS_UNIT_EN: per-grant millisecond units via a 1000-tick sub-counter.
module us_delay_arbiter
    import us_delay_pkg::*;
#(
    parameter int unsigned INPUT_CLK_FREQ = 100_000_000,
    parameter int unsigned TICK_FREQ      = 1_000_000,
    parameter int          NUM_REQ        = 2,
    parameter int          DELAY_W        = DELAY_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    us_delay_arbiter_if.slave bus
);
    localparam int unsigned DIV   = calc_div(INPUT_CLK_FREQ, TICK_FREQ);
    localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("us_delay_arbiter: INPUT_CLK_FREQ/TICK_FREQ must be an integer >= 2");
    end
    if (NUM_REQ < 1 || NUM_REQ > 4) begin : g_bad_num_req
        $error("us_delay_arbiter: NUM_REQ must be in 1..4");
    end

    state_t               r_state, w_state_nxt;
    logic [PTR_W-1:0]     r_ptr;
    logic [DELAY_W-1:0]   r_remaining;
    logic [NUM_REQ-1:0]   w_rot;
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic [PTR_W-1:0]     w_sel;
    logic [DELAY_W-1:0]   w_sel_delay;
    logic                 w_any;
    logic                 w_owner_req;
    logic                 w_tick;
    logic                 w_grant;
    logic                 w_dec;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [NUM_REQ-1:0]   w_done;
    logic                 w_busy;
`ifdef US_DELAY_MS_UNIT_EN
    logic                 r_unit_ms;
    logic [9:0]           r_sub;
    logic                 w_sel_ms;
`endif

    us_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_grant),
        .o_tick (w_tick)
    );

    // Rotate so bit 0 is the requester just above the pointer; first set bit wins.
    always_comb begin
        w_rot       = NUM_REQ'({bus.req, bus.req} >> (32'(r_ptr) + 32'd1));
        w_any       = 1'b0;
        w_sel       = '0;
        w_sel_delay = '0;
`ifdef US_DELAY_MS_UNIT_EN
        w_sel_ms    = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                w_sel = PTR_W'((32'(r_ptr) + 32'd1 + k) % NUM_REQ);
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_sel == PTR_W'(k)) begin
                w_sel_delay = bus.delay[k*DELAY_W +: DELAY_W];
`ifdef US_DELAY_MS_UNIT_EN
                w_sel_ms    = bus.unit_ms[k];
`endif
            end
        end
    end

    // The pointer is updated at every grant, so it also names the current owner.
    always_comb begin
        w_owner_oh  = '0;
        w_owner_req = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (r_ptr == PTR_W'(k)) begin
                w_owner_oh[k] = 1'b1;
                w_owner_req   = bus.req[k];
            end
        end
    end

`ifdef US_DELAY_MS_UNIT_EN
    assign w_dec = (r_state == COUNT) && w_tick && (!r_unit_ms || r_sub == 10'd999);
`else
    assign w_dec = (r_state == COUNT) && w_tick;
`endif

    // A zero delay spends one cycle in COUNT, which places done one cycle after gnt.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt       = '0;
        w_done      = '0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                w_gnt  = w_owner_oh;
                w_busy = 1'b1;
                if (!w_owner_req) begin
                    w_state_nxt = IDLE;
                end else if (r_remaining == '0) begin
                    w_state_nxt = DONE;
                end else if (w_dec && r_remaining == DELAY_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_gnt       = w_owner_oh;
                w_done      = w_owner_oh;
                w_busy      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= PTR_W'(NUM_REQ - 1);
            r_remaining <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_ptr       <= w_sel;
                r_remaining <= w_sel_delay;
            end else if (w_dec && r_remaining != '0) begin
                r_remaining <= r_remaining - DELAY_W'(1);
            end
        end
    end

`ifdef US_DELAY_MS_UNIT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_unit_ms <= 1'b0;
            r_sub     <= '0;
        end else if (w_grant) begin
            r_unit_ms <= w_sel_ms;
            r_sub     <= '0;
        end else if (r_state == COUNT && w_tick && r_unit_ms) begin
            r_sub <= (r_sub == 10'd999) ? '0 : r_sub + 10'd1;
        end
    end
`endif

    assign bus.gnt     = w_gnt;
    assign bus.done    = w_done;
    assign bus.busy    = w_busy;
    assign bus.us_tick = w_tick;

endmodule
